// File: rtl/dpsram_model_pkg.sv
// Shared types and constants for the dual-port SRAM model family.
package memory_pkg;

    typedef enum logic {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST
    } rdw_mode_e;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/dpsram_model_rd_pipe.sv
// Per-port read return pipeline: one or two register stages ahead of rdata/rvalid.
module sram_rd_pipe #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic [DATA_W-1:0] rd_word,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic              stg_valid;
    logic [DATA_W-1:0] stg_data;

    generate
        if (READ_LATENCY == 2) begin : g_extra_stage
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;

            always_ff @(posedge clk or negedge rstz) begin
                if (!rstz) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else begin
                    s1_valid <= rd_req;
                    if (rd_req) begin
                        s1_data <= rd_word;
                    end
                end
            end

            assign stg_valid = s1_valid;
            assign stg_data  = s1_data;
        end else begin : g_direct
            assign stg_valid = rd_req;
            assign stg_data  = rd_word;
        end
    endgenerate

    // rdata only loads on a valid result so it holds between reads
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= stg_valid;
            if (stg_valid) begin
                rdata <= stg_data;
            end
        end
    end

endmodule

// File: rtl/dpsram_model.sv
// True dual-port SRAM model: byte-masked writes, selectable cross-port
// read-during-write policy, configurable read latency and collision flag.
module dpsram_model
    import memory_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter rdw_mode_e   RDW_MODE     = RDW_READ_FIRST
) (
    input  logic                     clk,
    input  logic                     rstz,
    input  logic [31:0]              a_addr,
    input  logic [DATA_W-1:0]        a_wdata,
    output logic [DATA_W-1:0]        a_rdata,
    input  logic                     a_en,
    input  logic                     a_wr_en,
    input  logic [DATA_W/BYTE_W-1:0] a_wr_mask,
    output logic                     a_rvalid,
    input  logic [31:0]              b_addr,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic [DATA_W-1:0]        b_rdata,
    input  logic                     b_en,
    input  logic                     b_wr_en,
    input  logic [DATA_W/BYTE_W-1:0] b_wr_mask,
    output logic                     b_rvalid,
    output logic                     collision
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     a_idx, b_idx;
    logic              a_we, a_re, b_we, b_re, same_idx;
    logic [DATA_W-1:0] a_merged, b_merged, a_commit;
    logic [DATA_W-1:0] a_rd_word, b_rd_word;
    logic              unused_addr_bits;

    assign a_idx    = a_addr[AW-1:0];
    assign b_idx    = b_addr[AW-1:0];
    assign unused_addr_bits = ^{a_addr[31:AW], b_addr[31:AW]};

    assign a_we     = a_en & a_wr_en;
    assign a_re     = a_en & ~a_wr_en;
    assign b_we     = b_en & b_wr_en;
    assign b_re     = b_en & ~b_wr_en;
    assign same_idx = (a_idx == b_idx);

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     mask
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (mask[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // Port A merges on top of port B's result so A wins shared bytes on a dual write
    always_comb begin
        a_merged = merge_bytes(mem[a_idx], a_wdata, a_wr_mask);
        b_merged = merge_bytes(mem[b_idx], b_wdata, b_wr_mask);
        a_commit = (b_we && same_idx) ? merge_bytes(b_merged, a_wdata, a_wr_mask)
                                      : a_merged;
    end

    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_idx] <= b_merged;
        end
        if (a_we) begin
            mem[a_idx] <= a_commit;
        end
    end

    always_comb begin
        a_rd_word = mem[a_idx];
        b_rd_word = mem[b_idx];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (b_we && same_idx) begin
                a_rd_word = b_merged;
            end
            if (a_we && same_idx) begin
                b_rd_word = a_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            collision <= 1'b0;
        end else begin
            collision <= a_en & b_en & same_idx & (a_wr_en | b_wr_en);
        end
    end

    sram_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_a_pipe (
        .clk     (clk),
        .rstz    (rstz),
        .rd_word (a_rd_word),
        .rd_req  (a_re),
        .rdata   (a_rdata),
        .rvalid  (a_rvalid)
    );

    sram_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_b_pipe (
        .clk     (clk),
        .rstz    (rstz),
        .rd_word (b_rd_word),
        .rd_req  (b_re),
        .rdata   (b_rdata),
        .rvalid  (b_rvalid)
    );

endmodule

// File: tb/tb_dpsram_model.sv
// Bench for dpsram_model: two instances (latency 1 read-first, latency 2
// write-first) driven in lockstep and checked against a word-level model.
module tb_dpsram_model;
    import memory_pkg::*;

    logic        clk;
    logic        rstz;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_en, a_wr_en, b_en, b_wr_en;
    logic [3:0]  a_wr_mask, b_wr_mask;

    logic [31:0] rf_a_rdata, rf_b_rdata, wf_a_rdata, wf_b_rdata;
    logic        rf_a_rvalid, rf_b_rvalid, wf_a_rvalid, wf_b_rvalid;
    logic        rf_col, wf_col;

    int checks = 0;
    int errors = 0;

    dpsram_model #(
        .DEPTH(256), .DATA_W(32), .READ_LATENCY(1), .RDW_MODE(RDW_READ_FIRST)
    ) u_rf (
        .clk(clk), .rstz(rstz),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(rf_a_rdata), .a_en(a_en),
        .a_wr_en(a_wr_en), .a_wr_mask(a_wr_mask), .a_rvalid(rf_a_rvalid),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rf_b_rdata), .b_en(b_en),
        .b_wr_en(b_wr_en), .b_wr_mask(b_wr_mask), .b_rvalid(rf_b_rvalid),
        .collision(rf_col)
    );

    dpsram_model #(
        .DEPTH(256), .DATA_W(32), .READ_LATENCY(2), .RDW_MODE(RDW_WRITE_FIRST)
    ) u_wf (
        .clk(clk), .rstz(rstz),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(wf_a_rdata), .a_en(a_en),
        .a_wr_en(a_wr_en), .a_wr_mask(a_wr_mask), .a_rvalid(wf_a_rvalid),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(wf_b_rdata), .b_en(b_en),
        .b_wr_en(b_wr_en), .b_wr_mask(b_wr_mask), .b_rvalid(wf_b_rvalid),
        .collision(wf_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        ae, aw;
        logic [31:0] aa, ad;
        logic [3:0]  am;
        logic        be, bw;
        logic [31:0] ba, bd;
        logic [3:0]  bm;
        logic [31:0] e_ard;
        logic        e_arv;
        logic [31:0] e_brd;
        logic        e_brv;
        logic        e_col;
    } vec_t;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] e0_ard, e0_brd, e1_ard, e1_brd, p_aw, p_bw;
    logic        e0_arv, e0_brv, e1_arv, e1_brv, e_col, p_av, p_bv;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = w[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        e0_ard = '0; e0_brd = '0; e1_ard = '0; e1_brd = '0;
        e0_arv = 0; e0_brv = 0; e1_arv = 0; e1_brv = 0; e_col = 0;
        p_av = 0; p_bv = 0; p_aw = '0; p_bw = '0;
    endtask

    // One clock edge worth of behaviour, evaluated from pre-edge inputs
    task automatic model_step();
        int ai, bi;
        logic a_rd, a_w, b_rd, b_w;
        logic [31:0] old_a, old_b, wf_a, wf_b;
        ai = int'(a_addr % 256);
        bi = int'(b_addr % 256);
        a_rd = a_en && !a_wr_en; a_w = a_en && a_wr_en;
        b_rd = b_en && !b_wr_en; b_w = b_en && b_wr_en;
        old_a = m_mem[ai];
        old_b = m_mem[bi];
        wf_a = (b_w && ai == bi) ? merge(old_a, b_wdata, b_wr_mask) : old_a;
        wf_b = (a_w && ai == bi) ? merge(old_b, a_wdata, a_wr_mask) : old_b;
        e0_arv = a_rd; if (a_rd) e0_ard = old_a;
        e0_brv = b_rd; if (b_rd) e0_brd = old_b;
        e1_arv = p_av; if (p_av) e1_ard = p_aw;
        e1_brv = p_bv; if (p_bv) e1_brd = p_bw;
        p_av = a_rd; p_aw = wf_a;
        p_bv = b_rd; p_bw = wf_b;
        e_col = a_en && b_en && ai == bi && (a_wr_en || b_wr_en);
        if (b_w) m_mem[bi] = merge(m_mem[bi], b_wdata, b_wr_mask);
        if (a_w) m_mem[ai] = merge(m_mem[ai], a_wdata, a_wr_mask);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rf_a_rdata", rf_a_rdata, e0_ard);
        chk("rf_a_rvalid", {31'b0, rf_a_rvalid}, {31'b0, e0_arv});
        chk("rf_b_rdata", rf_b_rdata, e0_brd);
        chk("rf_b_rvalid", {31'b0, rf_b_rvalid}, {31'b0, e0_brv});
        chk("rf_collision", {31'b0, rf_col}, {31'b0, e_col});
        chk("wf_a_rdata", wf_a_rdata, e1_ard);
        chk("wf_a_rvalid", {31'b0, wf_a_rvalid}, {31'b0, e1_arv});
        chk("wf_b_rdata", wf_b_rdata, e1_brd);
        chk("wf_b_rvalid", {31'b0, wf_b_rvalid}, {31'b0, e1_brv});
        chk("wf_collision", {31'b0, wf_col}, {31'b0, e_col});
    endtask

    task automatic do_cycle(input vec_t v);
        a_en = v.ae; a_wr_en = v.aw; a_addr = v.aa; a_wdata = v.ad; a_wr_mask = v.am;
        b_en = v.be; b_wr_en = v.bw; b_addr = v.ba; b_wdata = v.bd; b_wr_mask = v.bm;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic vec_t mk(
        input logic ae, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
        input logic [3:0] am, input logic be, input logic bw, input logic [31:0] ba,
        input logic [31:0] bd, input logic [3:0] bm, input logic [31:0] ard,
        input logic arv, input logic [31:0] brd, input logic brv, input logic col);
        vec_t v;
        v.ae = ae; v.aw = aw; v.aa = aa; v.ad = ad; v.am = am;
        v.be = be; v.bw = bw; v.ba = ba; v.bd = bd; v.bm = bm;
        v.e_ard = ard; v.e_arv = arv; v.e_brd = brd; v.e_brv = brv; v.e_col = col;
        return v;
    endfunction

    vec_t tbl [21];
    vec_t idle_v, v;

    initial begin
        // Expected outputs are those of the latency-1 read-first instance
        tbl[0]  = mk(1,1,5,32'hDEADBEEF,4'hF, 0,0,0,0,0, 32'h0,0, 32'h0,0, 0);
        tbl[1]  = mk(1,1,5,32'h11223344,4'h5, 0,0,0,0,0, 32'h0,0, 32'h0,0, 0);
        tbl[2]  = mk(1,0,5,0,0, 0,0,0,0,0, 32'hDE22BE44,1, 32'h0,0, 0);
        tbl[3]  = mk(0,0,0,0,0, 1,1,0,32'hA0,4'hF, 32'hDE22BE44,0, 32'h0,0, 0);
        tbl[4]  = mk(0,0,0,0,0, 1,1,1,32'hA1,4'hF, 32'hDE22BE44,0, 32'h0,0, 0);
        tbl[5]  = mk(0,0,0,0,0, 1,1,2,32'hA2,4'hF, 32'hDE22BE44,0, 32'h0,0, 0);
        tbl[6]  = mk(0,0,0,0,0, 1,0,0,0,0, 32'hDE22BE44,0, 32'hA0,1, 0);
        tbl[7]  = mk(0,0,0,0,0, 1,0,1,0,0, 32'hDE22BE44,0, 32'hA1,1, 0);
        tbl[8]  = mk(0,0,0,0,0, 1,0,2,0,0, 32'hDE22BE44,0, 32'hA2,1, 0);
        tbl[9]  = mk(0,0,0,0,0, 0,0,0,0,0, 32'hDE22BE44,0, 32'hA2,0, 0);
        tbl[10] = mk(1,1,7,32'h0,4'hF, 0,0,0,0,0, 32'hDE22BE44,0, 32'hA2,0, 0);
        tbl[11] = mk(1,1,7,32'hFFFFFFFF,4'h3, 1,0,7,0,0, 32'hDE22BE44,0, 32'h0,1, 1);
        tbl[12] = mk(1,0,7,0,0, 0,0,0,0,0, 32'h0000FFFF,1, 32'h0,0, 0);
        tbl[13] = mk(1,1,3,32'h0,4'hF, 0,0,0,0,0, 32'h0000FFFF,0, 32'h0,0, 0);
        tbl[14] = mk(1,1,3,32'h11111111,4'hC, 1,1,3,32'h22222222,4'h6, 32'h0000FFFF,0, 32'h0,0, 1);
        tbl[15] = mk(0,0,0,0,0, 1,0,3,0,0, 32'h0000FFFF,0, 32'h11112200,1, 0);
        tbl[16] = mk(1,1,32'h100,32'hCAFEF00D,4'hF, 0,0,0,0,0, 32'h0000FFFF,0, 32'h11112200,0, 0);
        tbl[17] = mk(1,0,32'h100,0,0, 1,0,0,0,0, 32'hCAFEF00D,1, 32'hCAFEF00D,1, 0);
        tbl[18] = mk(0,0,0,0,0, 0,0,0,0,0, 32'hCAFEF00D,0, 32'hCAFEF00D,0, 0);
        tbl[19] = mk(1,1,32'h100,32'hFFFFFFFF,4'h0, 1,0,0,0,0, 32'hCAFEF00D,0, 32'hCAFEF00D,1, 1);
        tbl[20] = mk(1,0,0,0,0, 0,0,0,0,0, 32'hCAFEF00D,1, 32'hCAFEF00D,0, 0);
        idle_v = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);

        rstz = 1'b0;
        a_en = 0; a_wr_en = 0; a_addr = '0; a_wdata = '0; a_wr_mask = '0;
        b_en = 0; b_wr_en = 0; b_addr = '0; b_wdata = '0; b_wr_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rstz = 1'b1;

        // Give every word a known value
        for (int k = 0; k < 128; k++) begin
            v = mk(1,1,32'(2*k),$urandom,4'hF, 1,1,32'(2*k+1),$urandom,4'hF, 0,0,0,0,0);
            do_cycle(v);
        end

        rstz = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rstz = 1'b1;

        for (int i = 0; i < 21; i++) begin
            do_cycle(tbl[i]);
            chk($sformatf("tbl%0d_a_rdata", i), rf_a_rdata, tbl[i].e_ard);
            chk($sformatf("tbl%0d_a_rvalid", i), {31'b0, rf_a_rvalid}, {31'b0, tbl[i].e_arv});
            chk($sformatf("tbl%0d_b_rdata", i), rf_b_rdata, tbl[i].e_brd);
            chk($sformatf("tbl%0d_b_rvalid", i), {31'b0, rf_b_rvalid}, {31'b0, tbl[i].e_brv});
            chk($sformatf("tbl%0d_collision", i), {31'b0, rf_col}, {31'b0, tbl[i].e_col});
        end

        // Write-first instance sees the merged word for the addr 7 collision
        do_cycle(mk(1,1,7,32'h0,4'hF, 1,0,7,0,0, 0,0,0,0,0));
        do_cycle(mk(1,1,7,32'hFFFFFFFF,4'h3, 1,0,7,0,0, 0,0,0,0,0));
        do_cycle(idle_v);
        chk("wf_rdw_b_rdata", wf_b_rdata, 32'h0000FFFF);
        chk("wf_rdw_b_rvalid", {31'b0, wf_b_rvalid}, 32'h1);

        // Reset while a latency-2 read is in flight
        do_cycle(mk(1,0,5,0,0, 0,0,0,0,0, 0,0,0,0,0));
        #2;
        rstz = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_wf_a_rdata", wf_a_rdata, 32'h0);
        a_en = 0; b_en = 0;
        @(posedge clk);
        #1;
        compare_all();
        chk("rst_wf_a_rvalid", {31'b0, wf_a_rvalid}, 32'h0);
        rstz = 1'b1;
        do_cycle(idle_v);
        chk("post_rst_wf_a_rvalid", {31'b0, wf_a_rvalid}, 32'h0);
        do_cycle(mk(1,0,5,0,0, 0,0,0,0,0, 0,0,0,0,0));
        chk("reread_rf_a_rdata", rf_a_rdata, 32'hDE22BE44);
        do_cycle(idle_v);
        chk("reread_wf_a_rdata", wf_a_rdata, 32'hDE22BE44);
        chk("reread_wf_a_rvalid", {31'b0, wf_a_rvalid}, 32'h1);

        // Randomised traffic on a narrow index range with aliased upper bits
        for (int n = 0; n < 2000; n++) begin
            v.ae = ($urandom % 4) != 0;
            v.aw = $urandom % 2;
            v.aa = ($urandom % 2) ? (($urandom & 32'hFFFFFF00) | $urandom_range(0, 7))
                                  : 32'($urandom_range(0, 7));
            v.ad = $urandom;
            v.am = 4'($urandom);
            v.be = ($urandom % 4) != 0;
            v.bw = $urandom % 2;
            v.ba = ($urandom % 2) ? (($urandom & 32'hFFFFFF00) | $urandom_range(0, 7))
                                  : 32'($urandom_range(0, 7));
            v.bd = $urandom;
            v.bm = 4'($urandom);
            do_cycle(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpsram_model.md
Name: dpsram_model

Overview:
Parametrised true dual-port SRAM behavioural model. It is the successor to the single-port 32b model and is used for instruction/data memories and testbench backing stores where two masters share one array.
- Each port independently reads or byte-masked writes every cycle.
- Width, depth and read latency are configurable.
- Read-during-write resolution is selectable.
- Same-address collisions are flagged.

Parameters:
DEPTH, 256, number of words; power of two, >= 2
DATA_W, 32, word width in bits; multiple of 8
READ_LATENCY, 1, cycles from read request to rdata/rvalid; legal values 1 or 2
RDW_MODE, RDW_READ_FIRST, cross-port read-during-write policy (RDW_READ_FIRST or RDW_WRITE_FIRST)

Ports:
clk  in  1  clock; all activity on rising edge
rstz  in  1  reset, asynchronous, active-low
a_addr  in  32  port A word address; only low $clog2(DEPTH) bits used
a_wdata  in  DATA_W  port A write data
a_rdata  out  DATA_W  port A read data
a_en  in  1  port A access enable
a_wr_en  in  1  port A write (1) / read (0) select, qualified by a_en
a_wr_mask  in  DATA_W/8  port A byte write enables
a_rvalid  out  1  port A read data valid, one-cycle pulse per read
b_addr  in  32  port B word address
b_wdata  in  DATA_W  port B write data
b_rdata  out  DATA_W  port B read data
b_en  in  1  port B access enable
b_wr_en  in  1  port B write/read select
b_wr_mask  in  DATA_W/8  port B byte write enables
b_rvalid  out  1  port B read data valid
collision  out  1  registered pulse: both ports hit same word in previous cycle, at least one writing

Behaviour:
- Reset (rstz low, async):
  - a_rdata, b_rdata = 0; a_rvalid, b_rvalid = 0; collision = 0.
  - All read-pipeline stages are cleared.
  - Array contents are NOT reset; they are preserved across reset and are X until first written.
- Index = addr[$clog2(DEPTH)-1:0]. Upper address bits are ignored, so addr DEPTH aliases to addr 0.
- Write (en & wr_en):
  - Byte i of the word is updated iff wr_mask[i].
  - wr_mask = 0 is a legal no-op.
  - A write never raises rvalid; rdata holds its previous value.
- Read (en & !wr_en):
  - READ_LATENCY=1: word appears on rdata with rvalid=1 on the next edge.
  - READ_LATENCY=2: one extra register stage; rdata/rvalid appear two edges after the request.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
  - rdata holds its last value when rvalid=0.
- en=0: no array access; the pipeline still advances and rvalid drops.
- Cross-port read-during-write (one port reads index X while the other writes X in the same cycle):
  - RDW_READ_FIRST: reader gets the pre-write word.
  - RDW_WRITE_FIRST: reader gets the merged word: written bytes where mask is set, old bytes elsewhere.
- Dual write, same index: bytes enabled on only one port take that port's data; bytes enabled on both take port A (A wins).
- collision:
  - Set on the edge after a cycle where a_en & b_en & equal index & (a_wr_en | b_wr_en).
  - Cleared the following cycle unless the condition repeats.
  - Two reads of the same index do not flag.
- Reset asserted mid-read: pending results are dropped and no rvalid is produced for them. The first read after deassertion behaves normally.

Decomposition:
- Package memory_pkg holds:
  - enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST};
  - localparam BYTE_W = 8.
- Sub-module sram_rd_pipe(DATA_W, READ_LATENCY), instantiated once per port:
  - inputs: raw read word and request valid;
  - outputs: rdata/rvalid with async rstz clear of data and valid.
- The array, write merge, RDW muxing and collision detect live in dpsram_model.

Test Plan:
- Byte-masked write: A writes 0xDEADBEEF to addr 5 with mask 0xF; A writes 0x11223344 to addr 5 with mask 0b0101; A reads 5 -> a_rdata=0xDE22BE44, a_rvalid one cycle later (two with READ_LATENCY=2).
- Pipelined reads: B reads addrs 0,1,2 on consecutive cycles, holding 0xA0/0xA1/0xA2 -> b_rvalid high three consecutive cycles, data in order; b_rdata holds 0xA2 afterwards.
- Read-during-write: addr 7 = 0x00000000; A writes 0xFFFFFFFF mask 0x3 while B reads 7:
  - READ_FIRST -> b_rdata=0x00000000;
  - WRITE_FIRST -> b_rdata=0x0000FFFF;
  - collision=1 next cycle in both modes.
- Dual write: A writes 0x11111111 mask 0xC and B writes 0x22222222 mask 0x6 to addr 3 -> later read gives 0x11112200 over prior 0x00000000; collision pulses once.
- Aliasing and reset: DEPTH=256, write addr 0x100 then read addr 0 -> data matches. Assert rstz low for one cycle while a READ_LATENCY=2 read is in flight -> no rvalid, rdata=0, array contents intact on re-read.
